// File: rtl/digit_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared constants and types for the 8-digit seven-segment scan controller.
//   DIGITS / SEL_W / NIB_W : display geometry
//   scan_state_t           : scan FSM state (IDLE, DWELL)
//   sel_t, nib_t           : digit index and digit value types
//   nibble_at()            : extracts digit value idx from the packed data word
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int DIGITS = 8;
    localparam int SEL_W  = 3;
    localparam int NIB_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } scan_state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NIB_W-1:0] nib_t;

    function automatic nib_t nibble_at(input logic [DIGITS*NIB_W-1:0] d,
                                       input sel_t                    idx);
        return d[idx*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl_if
// Bundles the scan controller's control inputs and display-side outputs.
//   en, mask, data        : driven by the master (display top / host)
//   sel, nibble, active,
//   wrap, state           : driven by the slave (digit_scan_ctrl)
// All signals are level-sampled on the rising clock edge; there is no
// valid/ready handshake. state is a debug view of the scan FSM.
// -----------------------------------------------------------------------------
interface digit_scan_ctrl_if;
    import scan_pkg::*;

    logic                    en;
    logic [DIGITS-1:0]       mask;
    logic [DIGITS*NIB_W-1:0] data;
    sel_t                    sel;
    nib_t                    nibble;
    logic                    active;
    logic                    wrap;
    scan_state_t             state;

    modport master (
        output en, mask, data,
        input  sel, nibble, active, wrap, state
    );

    modport slave (
        input  en, mask, data,
        output sel, nibble, active, wrap, state
    );

endinterface

// File: rtl/digit_scan_ctrl_next_enabled.sv
// -----------------------------------------------------------------------------
// next_enabled
// Purely combinational search for the next enabled digit strictly after cur,
// ascending, modulo DIGITS.
//   cur     : current digit index
//   mask    : digit enable bits
//   nxt     : next enabled digit (cur itself if it is the only one enabled,
//             cur if mask is all zero)
//   wrapped : the search crossed or landed back on cur (nxt <= cur)
// -----------------------------------------------------------------------------
module next_enabled
    import scan_pkg::*;
(
    input  sel_t              cur,
    input  logic [DIGITS-1:0] mask,
    output sel_t              nxt,
    output logic              wrapped
);

    sel_t cand;
    logic found;

    // Offsets 1..DIGITS; the last offset wraps to cur itself so a lone
    // enabled digit selects itself. The first hit wins.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = cur;
        for (int i = 1; i <= DIGITS; i++) begin
            cand = cur + sel_t'(i);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        wrapped = found && (nxt <= cur);
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl
// Time-multiplexing scan controller for an 8-digit seven-segment display.
// Dwells TICK_DIV clocks on each enabled digit, skipping disabled digits.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   bus   : slave side of digit_scan_ctrl_if
//           en     - scan enable (low freezes scanning)
//           mask   - digit enables, bit i enables digit i
//           data   - digit values, nibble i = data[4i+3:4i]
//           sel    - current digit index (to decoder A)
//           nibble - value of digit sel
//           active - mask bit of digit sel
//           wrap   - one-cycle pulse after a tick that completed a pass
//           state  - scan FSM state
// All outputs are registered.
// -----------------------------------------------------------------------------
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
)(
    input  logic              clk,
    input  logic              rst,
    digit_scan_ctrl_if.slave  bus
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    sel_t             sel;
    sel_t             sel_next;
    nib_t             nibble;
    logic             active;
    logic             wrap;
    logic             wrap_next;
    logic             go;
    logic             tick;
    sel_t             nxt;
    logic             wrapped;

    assign go = bus.en && (bus.mask != '0);

    next_enabled u_next_enabled (
        .cur     (sel),
        .mask    (bus.mask),
        .nxt     (nxt),
        .wrapped (wrapped)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go)  state_next = DWELL;
            DWELL:   if (!go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values. A tick needs go as well, so dropping
    // en (or clearing mask) on the last dwell cycle suppresses the advance.
    always_comb begin
        tick      = (state == DWELL) && go && (cnt == CNT_LAST);
        cnt_next  = '0;
        sel_next  = sel;
        wrap_next = 1'b0;
        if ((state == DWELL) && go) begin
            cnt_next = tick ? '0 : cnt + CNT_W'(1);
        end
        if (tick) begin
            sel_next  = nxt;
            wrap_next = wrapped;
        end
    end

    // nibble/active are taken from sel_next so they line up with sel and
    // follow data/mask with exactly one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sel    <= '0;
            nibble <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            sel    <= sel_next;
            nibble <= nibble_at(bus.data, sel_next);
            active <= bus.mask[sel_next];
            wrap   <= wrap_next;
        end
    end

    assign bus.sel    = sel;
    assign bus.nibble = nibble;
    assign bus.active = active;
    assign bus.wrap   = wrap;
    assign bus.state  = state;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_ctrl
// Self-checking bench for digit_scan_ctrl with TICK_DIV=4: a cycle-vector
// table, hand-written corner sequences and randomized traffic compared
// against a behavioural model.
// -----------------------------------------------------------------------------
module tb_digit_scan_ctrl;
    import scan_pkg::*;

    localparam int TD = 4;
    localparam logic [31:0] D0 = 32'h7654_3210;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_scan_ctrl_if bus ();

    digit_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Expected record: {sel[2:0], nibble[3:0], active, wrap, dwelling}
    logic [9:0] exp_q[$];

    logic [2:0] m_sel   = 3'd0;
    logic [3:0] m_nib   = 4'd0;
    logic       m_act   = 1'b0;
    logic       m_wrap  = 1'b0;
    logic       m_run   = 1'b0;
    int         m_phase = 0;

    function automatic logic [2:0] next_on(input logic [2:0] s, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (int'(s) + k) % 8;
            if (m[c]) return 3'(c);
        end
        return s;
    endfunction

    task automatic model_clock();
        logic       go;
        logic       adv;
        logic [2:0] old;
        if (rst) begin
            m_sel = 0; m_nib = 0; m_act = 0; m_wrap = 0; m_run = 0; m_phase = 0;
        end else begin
            go  = bus.en && (bus.mask != 8'h00);
            adv = m_run && go && (m_phase == TD - 1);
            old = m_sel;
            if (adv) m_sel = next_on(m_sel, bus.mask);
            m_phase = (m_run && go && !adv) ? m_phase + 1 : 0;
            m_run   = go;
            m_wrap  = adv && (m_sel <= old);
            m_nib   = 4'((bus.data >> (4 * int'(m_sel))) & 32'hF);
            m_act   = bus.mask[m_sel];
        end
        exp_q.push_back({m_sel, m_nib, m_act, m_wrap, m_run});
    endtask

    task automatic check_model();
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            check("model_queue_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("sel",    32'(bus.sel),              32'(e[9:7]));
        check("nibble", 32'(bus.nibble),           32'(e[6:3]));
        check("active", 32'(bus.active),           32'(e[2]));
        check("wrap",   32'(bus.wrap),             32'(e[1]));
        check("state",  32'(bus.state == DWELL),   32'(e[0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit chk);
        @(posedge clk);
        model_clock();
        #1;
        if (chk) check_model();
        else     exp_q.delete();
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] m, input logic [31:0] d);
        rst      = r;
        bus.en   = e;
        bus.mask = m;
        bus.data = d;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00, D0);
        step(1'b1);
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  mask;
        logic [31:0] data;
        logic [2:0]  e_sel;
        logic [3:0]  e_nib;
        logic        e_act;
        logic        e_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] m, input logic [31:0] d,
                       input logic [2:0] s, input logic [3:0] n, input logic a, input logic w,
                       input int reps = 1);
        vec_t v;
        v.rst = r; v.en = e; v.mask = m; v.data = d;
        v.e_sel = s; v.e_nib = n; v.e_act = a; v.e_wrap = w;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         wraps;
        int         exp_sel;
        logic [7:0] mk;

        bus.en   = 1'b0;
        bus.mask = 8'h00;
        bus.data = 32'h0;

        // mask 1000_0101: 0,2,7,0,2 ; wrap only on 7->0
        add(1, 0, 8'h85, D0, 0, 0, 0, 0);
        add(0, 1, 8'h85, D0, 0, 0, 1, 0, 4);
        add(0, 1, 8'h85, D0, 2, 2, 1, 0);
        add(0, 1, 8'h85, D0, 2, 2, 1, 0, 3);
        add(0, 1, 8'h85, D0, 7, 7, 1, 0);
        add(0, 1, 8'h85, D0, 7, 7, 1, 0, 3);
        add(0, 1, 8'h85, D0, 0, 0, 1, 1);
        add(0, 1, 8'h85, D0, 0, 0, 1, 0, 3);
        add(0, 1, 8'h85, D0, 2, 2, 1, 0);
        // single enabled digit 4 from reset
        add(1, 0, 8'h10, D0, 0, 0, 0, 0);
        add(0, 1, 8'h10, D0, 0, 0, 0, 0, 4);
        add(0, 1, 8'h10, D0, 4, 4, 1, 0);
        add(0, 1, 8'h10, D0, 4, 4, 1, 0, 3);
        add(0, 1, 8'h10, D0, 4, 4, 1, 1);
        add(0, 1, 8'h10, D0, 4, 4, 1, 0, 3);
        add(0, 1, 8'h10, D0, 4, 4, 1, 1);
        // mid-dwell data then mask change; sel holds until the tick
        add(0, 1, 8'h10, 32'hFEDC_BA98, 4, 4'hC, 1, 0);
        add(0, 1, 8'h01, 32'hFEDC_BA98, 4, 4'hC, 0, 0, 2);
        add(0, 1, 8'h01, 32'hFEDC_BA98, 0, 4'h8, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mask, vecs[i].data);
            step(1'b0);
            check($sformatf("vec%0d_sel", i),    32'(bus.sel),    32'(vecs[i].e_sel));
            check($sformatf("vec%0d_nibble", i), 32'(bus.nibble), 32'(vecs[i].e_nib));
            check($sformatf("vec%0d_active", i), 32'(bus.active), 32'(vecs[i].e_act));
            check($sformatf("vec%0d_wrap", i),   32'(bus.wrap),   32'(vecs[i].e_wrap));
        end

        // Reset state
        do_reset();
        check("rst_state", 32'(bus.state == IDLE), 32'd1);

        // Full scan 0..7,0 with every digit enabled
        drive(1'b0, 1'b1, 8'hFF, D0);
        wraps = 0;
        for (int i = 1; i <= 33; i++) begin
            step(1'b1);
            exp_sel = ((i - 1) / TD) % 8;
            check("full_sel",    32'(bus.sel),    32'(exp_sel));
            check("full_nibble", 32'(bus.nibble), 32'(exp_sel));
            check("full_wrap",   32'(bus.wrap),   32'(i == 33));
            if (bus.wrap) wraps++;
        end
        check("full_wrap_count", 32'(wraps), 32'd1);

        // mask cleared mid-dwell, then restored
        do_reset();
        drive(1'b0, 1'b1, 8'hFF, D0);
        repeat (6) step(1'b1);
        bus.mask = 8'h00;
        step(1'b1);
        check("mask0_sel",    32'(bus.sel),              32'd1);
        check("mask0_active", 32'(bus.active),           32'd0);
        check("mask0_idle",   32'(bus.state == IDLE),    32'd1);
        bus.mask = 8'hFF;
        repeat (4) step(1'b1);
        check("restore_hold", 32'(bus.sel), 32'd1);
        step(1'b1);
        check("restore_adv",  32'(bus.sel), 32'd2);

        // en dropped on the tick cycle; data change while frozen
        do_reset();
        drive(1'b0, 1'b1, 8'hFF, D0);
        repeat (4) step(1'b1);
        bus.en = 1'b0;
        step(1'b1);
        check("endrop_sel", 32'(bus.sel), 32'd0);
        step(1'b1);
        bus.data = 32'h7654_3219;
        step(1'b1);
        check("frozen_nibble", 32'(bus.nibble), 32'h9);
        bus.en = 1'b1;
        repeat (4) step(1'b1);
        check("en_back_hold", 32'(bus.sel), 32'd0);
        step(1'b1);
        check("en_back_adv",  32'(bus.sel), 32'd1);

        // reset mid-dwell at sel=5
        do_reset();
        drive(1'b0, 1'b1, 8'hFF, D0);
        repeat (21) step(1'b1);
        check("pre_rst_sel", 32'(bus.sel), 32'd5);
        rst = 1'b1;
        step(1'b1);
        check("rst5_sel",    32'(bus.sel),           32'd0);
        check("rst5_nibble", 32'(bus.nibble),        32'd0);
        check("rst5_active", 32'(bus.active),        32'd0);
        check("rst5_wrap",   32'(bus.wrap),          32'd0);
        check("rst5_idle",   32'(bus.state == IDLE), 32'd1);
        rst = 1'b0;

        // randomized traffic against the model
        do_reset();
        drive(1'b0, 1'b1, 8'($urandom), $urandom);
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mk = 8'h00;
                    1:       mk = 8'h01 << $urandom_range(0, 7);
                    default: mk = 8'($urandom);
                endcase
                bus.mask = mk;
            end
            if ($urandom_range(0, 3) == 0) bus.data = $urandom;
            step(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
